// File: rtl/serial_rx_ctrl.sv
// Serial receive controller: synchronizes rx, sequences an external 16x sampling counter,
// assembles DATA_BITS data bits LSB first and hands each good word to a consumer.
module serial_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 bsc_middle,
    input  logic                 bsc_end,
    input  logic                 data_ack,
    output logic                 bsc_en,
    output logic                 bsc_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int CW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS:0]     shift_cat;
    logic [CW-1:0]          bit_cnt;
    logic                   good_stop;
    logic                   bad_stop;
    logic                   take_ack;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign shift_cat = {rx_s, shreg};
    assign good_stop = (state == STOP) && bsc_middle && rx_s;
    assign bad_stop  = (state == STOP) && bsc_middle && !rx_s;
    assign take_ack  = data_valid && data_ack;

    // Idle-high reset value keeps a reset release from looking like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bsc_en     = 1'b0;
        bsc_clr    = 1'b0;
        case (state)
            IDLE: begin
                bsc_clr = 1'b1;
                if (!rx_s) state_next = START;
            end
            START: begin
                bsc_en = 1'b1;
                if (bsc_middle && rx_s) state_next = IDLE;
                else if (bsc_end)       state_next = DATA;
            end
            DATA: begin
                bsc_en = 1'b1;
                if (bsc_end && (bit_cnt == LAST_BIT)) state_next = STOP;
            end
            STOP: begin
                bsc_en = 1'b1;
                if (bsc_middle) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Handshake: data_valid=1 means data_out holds an unconsumed word; the word is taken at
    // any edge where data_valid && data_ack. A good frame landing on that same edge replaces
    // the word and keeps data_valid high; without an ack it only raises sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if ((state == START) && bsc_end) begin
                bit_cnt <= '0;
            end else if ((state == DATA) && bsc_end && (bit_cnt != LAST_BIT)) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if ((state == DATA) && bsc_middle) begin
                shreg <= shift_cat[DATA_BITS:1];
            end
            if (good_stop) begin
                if (!data_valid || data_ack) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                    if (data_valid) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (take_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: models the external 16x sampling counter, drives whole frames
// bit by bit, and checks a vector table, hand sequences and a randomized run against a model.
module tb_serial_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic       bsc_middle;
    logic       bsc_end;
    logic       bsc_en;
    logic       bsc_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [1:0] state_dbg;
    logic [3:0] cnt = 4'd0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        int         ack_at;
        int         gap;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_err;
        logic       e_ovr;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // External sampling counter as seen by the controller.
    always @(posedge clk) begin
        if (bsc_clr)     cnt <= 4'd0;
        else if (bsc_en) cnt <= cnt + 4'd1;
    end
    assign bsc_middle = (cnt == 4'd7);
    assign bsc_end    = (cnt == 4'd15);

    serial_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .bsc_middle (bsc_middle),
        .bsc_end    (bsc_end),
        .data_ack   (data_ack),
        .bsc_en     (bsc_en),
        .bsc_clr    (bsc_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic rx_v, input logic ack_v);
        rx       = rx_v;
        data_ack = ack_v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    // Edge e of the frame is the e-th edge after rx first goes low; stop middle is edge 154.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int ack_at,
                              output logic [7:0] o_data, output logic o_valid,
                              output logic o_err, output logic o_ovr,
                              output logic o_err_next, output logic o_valid_pre);
        logic [9:0] bits;
        bits = {stopb, d, 1'b0};
        for (int e = 0; e < 160; e++) begin
            step(bits[e/16], (e == ack_at));
            if (e == 153) o_valid_pre = data_valid;
            if (e == 154) begin
                o_data  = data_out;
                o_valid = data_valid;
                o_err   = frame_err;
                o_ovr   = overrun;
            end
            if (e == 155) o_err_next = frame_err;
        end
        data_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] o_data;
        logic       o_valid, o_err, o_ovr, o_err_next, o_valid_pre;
        logic       m_valid, m_ovr, m_err;
        logic [7:0] d;
        logic       stopb;
        int         ack_at;
        int         busy_cycles;
        logic       err_seen;
        logic [9:0] bits;

        vecs[0] = '{8'h3C, 1'b0, -1,  24, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, -1,   2, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 60,   0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, -1,   0, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h33, 1'b0, -1,  24, 8'h11, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h44, 1'b1, 100,  2, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 1'b1, -1,   0, 8'h44, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h22, 1'b1, 154,  3, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h66, 1'b1, 154,  2, 8'h66, 1'b1, 1'b0, 1'b0};

        // Reset with rx toggling.
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_bsc_clr", 32'(bsc_clr), 32'h1);
        check("rst_bsc_en", 32'(bsc_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        idle(4);

        // Clean 0xA5 frame, then a one-cycle ack.
        send_frame(8'hA5, 1'b1, -1, o_data, o_valid, o_err, o_ovr, o_err_next, o_valid_pre);
        check("a5_valid_before_stop", 32'(o_valid_pre), 32'h0);
        check("a5_valid", 32'(o_valid), 32'h1);
        check("a5_data", 32'(o_data), 32'hA5);
        check("a5_frame_err", 32'(o_err), 32'h0);
        step(1'b1, 1'b1);
        check("a5_ack_clears_valid", 32'(data_valid), 32'h0);
        check("a5_data_kept", 32'(data_out), 32'hA5);
        idle(3);

        // Short low glitch: busy only for the start-bit window up to its middle.
        busy_cycles = 0;
        err_seen    = 1'b0;
        for (int e = 0; e < 24; e++) begin
            step((e < 4) ? 1'b0 : 1'b1, 1'b0);
            if (busy) busy_cycles++;
            if (frame_err) err_seen = 1'b1;
        end
        check("glitch_busy_cycles", 32'(busy_cycles), 32'd8);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_no_err", 32'(err_seen), 32'h0);
        check("glitch_no_valid", 32'(data_valid), 32'h0);

        // Table of frames with known outcomes.
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].d, vecs[i].stopb, vecs[i].ack_at,
                       o_data, o_valid, o_err, o_ovr, o_err_next, o_valid_pre);
            check($sformatf("vec%0d_data", i), 32'(o_data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_frame_err", i), 32'(o_err), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_overrun", i), 32'(o_ovr), 32'(vecs[i].e_ovr));
            check($sformatf("vec%0d_err_pulse_end", i), 32'(o_err_next), 32'h0);
            idle(vecs[i].gap);
        end

        // Reset during data bit 4 aborts the frame; next frame is clean.
        bits = {1'b1, 8'hC3, 1'b0};
        for (int e = 0; e < 86; e++) step(bits[e/16], 1'b0);
        rst = 1'b0;
        step(bits[86/16], 1'b0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_bsc_clr", 32'(bsc_clr), 32'h1);
        check("midrst_bsc_en", 32'(bsc_en), 32'h0);
        check("midrst_valid", 32'(data_valid), 32'h0);
        check("midrst_data", 32'(data_out), 32'h0);
        rst = 1'b1;
        idle(20);
        send_frame(8'hFF, 1'b1, -1, o_data, o_valid, o_err, o_ovr, o_err_next, o_valid_pre);
        check("ff_data", 32'(o_data), 32'hFF);
        check("ff_valid", 32'(o_valid), 32'h1);
        check("ff_frame_err", 32'(o_err), 32'h0);
        idle(3);

        // Randomized frames against a frame-level model.
        rst = 1'b0;
        step(1'b1, 1'b0);
        rst = 1'b1;
        idle(3);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 14; i++) begin
            d      = 8'($urandom_range(0, 255));
            stopb  = ($urandom_range(0, 3) != 0);
            ack_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 140)) : -1;
            if (ack_at >= 0 && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            m_err = !stopb;
            if (stopb) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    exp_q.push_back(d);
                end else begin
                    m_ovr = 1'b1;
                end
            end
            send_frame(d, stopb, ack_at, o_data, o_valid, o_err, o_ovr, o_err_next, o_valid_pre);
            check($sformatf("rnd%0d_data", i), 32'(o_data), 32'(exp_q[$]));
            check($sformatf("rnd%0d_valid", i), 32'(o_valid), 32'(m_valid));
            check($sformatf("rnd%0d_frame_err", i), 32'(o_err), 32'(m_err));
            check($sformatf("rnd%0d_overrun", i), 32'(o_ovr), 32'(m_ovr));
            idle(stopb ? int'($urandom_range(0, 6)) : int'($urandom_range(20, 30)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
- Receive controller for the serial network.
- Sequences an external 16x bit-sampling counter. That counter is 4 bits, has an active-high clear, a count enable, decodes middle = count 7 and end = count 15, and wraps 15 -> 0.
- Detects the start bit, samples each data bit at mid-bit, checks the stop bit, and hands the assembled word to a consumer through a valid/ack handshake.
- `clk` runs at 16x the baud rate.

Parameters:
- DATA_BITS, 8, data bits per frame (1..16); shipped LSB first.
- SYNC_STAGES, 2, flops in the rx synchronizer (>=2).

Ports:
- clk  in  1  system clock, 16x baud.
- rst  in  1  synchronous, active-low reset (rst==0 resets at the clk edge).
- rx  in  1  asynchronous serial line; idle high.
- bsc_middle  in  1  sampling counter == 7.
- bsc_end  in  1  sampling counter == 15.
- data_ack  in  1  consumer has taken data_out.
- bsc_en  out  1  sampling counter count enable.
- bsc_clr  out  1  sampling counter clear, active high.
- data_out  out  DATA_BITS  last good received word.
- data_valid  out  1  data_out holds an unconsumed word.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a good frame completed while data_valid=1.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, all synchronizer flops=1, shift register=0, bit_cnt=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0.
  - Reset asserted mid-frame aborts the frame and loses its partial data.
- rx_s is rx delayed through SYNC_STAGES flops. All decisions use rx_s only.
- Moore decode of state:
  - bsc_clr=1 and bsc_en=0 in IDLE.
  - bsc_clr=0 and bsc_en=1 in START, DATA and STOP.
  - busy = (state != IDLE).
- IDLE:
  - rx_s==0 -> START.
  - The counter is held at 0 while in IDLE, so it reads 0 on the first START cycle.
- START:
  - On bsc_middle with rx_s==1: false start (glitch) -> IDLE, no error flagged.
  - On bsc_middle with rx_s==0: stay in START.
  - On bsc_end -> DATA, bit_cnt=0.
- DATA:
  - On bsc_middle: shift right and insert rx_s at the MSB. After DATA_BITS shifts, bit 0 holds the first received bit.
  - On bsc_end with bit_cnt==DATA_BITS-1 -> STOP.
  - On bsc_end otherwise: bit_cnt+1.
  - bit_cnt width is clog2(DATA_BITS)+1.
- STOP, on bsc_middle (then -> IDLE in all cases; this leaves half a bit to catch the next start edge):
  - rx_s==1, data_valid==0 or data_ack==1: data_out<=shift register, data_valid<=1.
  - rx_s==1, data_valid==1 and data_ack==0: data_out unchanged, overrun<=1.
  - rx_s==0: frame_err=1 for exactly one cycle; shift register discarded; data_valid and data_out unchanged.
- Handshake:
  - data_ack sampled while data_valid==1 clears data_valid and overrun at the next edge, unless a good frame completes on that same edge. In that case data_valid stays 1, data_out takes the new word, and overrun=0.
  - data_ack while data_valid==0 is ignored.
- The controller never relies on the counter's value other than bsc_middle/bsc_end. Counter wrap 15->0 inside a frame is expected and needs no action.
- Frame timing: E0 is the first edge at which rx==0 is sampled.
  - rx_s goes low after edge E(SYNC_STAGES-1).
  - START is entered at E(SYNC_STAGES).
  - Start-bit middle is sampled at E(SYNC_STAGES+8).
  - Data bit i is sampled 16*(i+1) edges later.
  - The stop bit is sampled at E(SYNC_STAGES+8+16*(DATA_BITS+1)), which is E154 for the defaults.
  - data_valid is visible in the cycle after that edge.

Test Plan:
- rst=0 for 2 cycles with rx toggling -> all outputs 0, bsc_clr=1, bsc_en=0, busy=0.
- Defaults; frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1), 16 clk per bit -> data_valid rises after E154, data_out=0xA5, frame_err=0; data_ack one cycle -> data_valid=0 next cycle.
- rx low for 4 cycles only, then high -> busy for one start-bit window, returns to IDLE at the start middle, data_valid and frame_err stay 0.
- Frame 0x3C with stop bit 0 -> one-cycle frame_err pulse at the stop middle, data_valid stays 0, then a clean 0x5A frame -> data_out=0x5A.
- Frames 0x11 then 0x22 back-to-back, no ack -> data_out=0x11, overrun=1. Repeat, with data_ack on the exact edge 0x22 completes -> data_out=0x22, data_valid=1, overrun=0.
- rst=0 during data bit 4 of a frame -> IDLE next edge, bsc_clr=1; the next full frame 0xFF is received correctly.
